// File: rtl/wb_ram_burst_ctrl.sv
// Wishbone B4 slave front-end for a single-port byte-enabled RAM: zero-wait writes, reads ack one cycle after request.
// Bursts run at one beat per cycle. Dropping stb inserts wait states and re-presents the current address.
module wb_ram_burst_ctrl #(
  parameter int    Dw         = 32,
  parameter int    Aw         = 10,
  parameter int    SELw       = Dw / 8,
  parameter string BURST_MODE = "ENABLED"
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [Dw-1:0]   sa_dat_i,
  input  logic [SELw-1:0] sa_sel_i,
  input  logic [Aw-1:0]   sa_addr_i,
  input  logic [2:0]      sa_cti_i,
  input  logic [1:0]      sa_bte_i,
  input  logic            sa_stb_i,
  input  logic            sa_cyc_i,
  input  logic            sa_we_i,
  output logic [Dw-1:0]   sa_dat_o,
  output logic            sa_ack_o,
  output logic            sa_err_o,
  output logic            sa_rty_o,
  output logic [Dw-1:0]   ram_data_o,
  output logic [Aw-1:0]   ram_addr_o,
  output logic [SELw-1:0] ram_byteen_o,
  output logic            ram_we_o,
  input  logic [Dw-1:0]   ram_q_i
);

  typedef enum logic {IDLE, READ} state_t;

  localparam bit BurstEn = (BURST_MODE == "ENABLED");

  state_t        state;
  logic [Aw-1:0] cur_addr;
  logic [Aw-1:0] nxt_addr;
  logic [Aw-1:0] wrap_mask;
  logic          req;
  logic          bad_cti;
  logic          wr;
  logic          rd_req;
  logic          rd_ack;
  logic          burst_cont;

  assign req        = sa_stb_i & sa_cyc_i;
  assign bad_cti    = (sa_cti_i >= 3'b011) && (sa_cti_i <= 3'b110);
  assign wr         = req & sa_we_i & ~bad_cti;
  assign rd_req     = req & ~sa_we_i & ~bad_cti;
  assign rd_ack     = (state == READ) & rd_req;
  assign burst_cont = rd_ack & BurstEn & (sa_cti_i == 3'b010);

  // Wrap bursts only let the low bits selected by the mask advance.
  always_comb begin
    case (sa_bte_i)
      2'b01:   wrap_mask = Aw'(3);
      2'b10:   wrap_mask = Aw'(7);
      2'b11:   wrap_mask = Aw'(15);
      default: wrap_mask = '1;
    endcase
  end

  assign nxt_addr = (cur_addr & ~wrap_mask) | ((cur_addr + Aw'(1)) & wrap_mask);

  assign sa_ack_o     = reset_n & (wr | rd_ack);
  assign sa_err_o     = reset_n & req & bad_cti;
  assign sa_rty_o     = 1'b0;
  assign ram_we_o     = reset_n & wr;
  assign sa_dat_o     = ram_q_i;
  assign ram_data_o   = sa_dat_i;
  assign ram_byteen_o = sa_sel_i;

  // In READ the RAM side owns the address so the next beat is already in flight.
  always_comb begin
    ram_addr_o = sa_addr_i;
    if (state == READ && !wr)
      ram_addr_o = burst_cont ? nxt_addr : cur_addr;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cur_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (rd_req) begin
            state    <= READ;
            cur_addr <= sa_addr_i;
          end
        end
        READ: begin
          if (!sa_cyc_i || wr || (req && bad_cti))
            state <= IDLE;
          else if (burst_cont)
            cur_addr <= nxt_addr;
          else if (rd_ack)
            state <= IDLE;
        end
      endcase
    end
  end

endmodule
